vga_monitor: RTL and testbench

VGA_MONITOR -- requirements
Module: vga_monitor

---
 rtl/vga_pkg.sv | 35 +++
 rtl/sync_edge.sv | 25 ++
 rtl/vga_monitor.sv | 174 +++++++++++++++++
 tb/tb_vga_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants, the counter type and the monitor
// state encoding used by the VGA timing monitor.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [9:0] cnt_t;
  localparam cnt_t CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

  // Increment that sticks at the top of the counter range.
  function automatic cnt_t sat_inc(input cnt_t v);
    if (v == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + 10'd1;
    end
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Edge detector for one already-sampled, active-low sync line.
// The history register idles high so no edge is seen out of reset.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_smp,
  output logic fall,
  output logic rise
);

  logic prev_r;

  // Previous sample of the sync line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= sync_smp;
    end
  end

  assign fall = prev_r & ~sync_smp;
  assign rise = ~prev_r & sync_smp;

endmodule

// File: rtl/vga_monitor.sv
// VGA timing monitor: measures line/frame timing of the incoming syncs, locks
// when it matches the parameters and reports a per-frame pixel checksum.
module vga_monitor
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        clr_err,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [31:0] checksum,
  output logic [18:0] pix_count,
  output logic        err_hperiod,
  output logic        err_vperiod,
  output logic        err_hwidth
);

  localparam cnt_t H_LAST   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t H_SYNC_W = cnt_t'(H_SYNC);
  localparam cnt_t H_ACT_LO = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t H_ACT_HI = cnt_t'(H_SYNC + H_BACK + H_VISIBLE);
  localparam cnt_t V_ACT_LO = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_ACT_HI = cnt_t'(V_SYNC + V_BACK + V_VISIBLE);

  logic        hs_r, vs_r;
  logic [11:0] pix_r;
  logic        hfall_s, hrise_s, vfall_s, vrise_unused_s;

  cnt_t        hcount_r, hcount_s, vcount_r, vcount_s, hlow_r, hlow_s;
  logic        h_seen_r;
  logic [31:0] sum_r, sum_s;
  logic [18:0] cnt_r, cnt_s;
  mon_state_e  state_r, state_s;

  logic        hper_ev_s, vper_ev_s, hwid_ev_s, err_ev_s, vis_s, latch_s;

  // Input sample stage; everything downstream sees only these registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      pix_r <= 12'd0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      pix_r <= {r, g, b};
    end
  end

  sync_edge u_hedge (.clk(clk), .rst(rst), .sync_smp(hs_r), .fall(hfall_s), .rise(hrise_s));
  sync_edge u_vedge (.clk(clk), .rst(rst), .sync_smp(vs_r), .fall(vfall_s), .rise(vrise_unused_s));

  // Position of the current sampled pixel; a coincident vsync fall zeroes both.
  always_comb begin
    hcount_s = hfall_s ? 10'd0 : sat_inc(hcount_r);
    vcount_s = vcount_r;
    if (vfall_s) begin
      vcount_s = 10'd0;
    end else if (hfall_s) begin
      vcount_s = sat_inc(vcount_r);
    end else begin
      vcount_s = vcount_r;
    end
    hlow_s = hlow_r;
    if (hfall_s) begin
      hlow_s = 10'd1;
    end else if (!hs_r) begin
      hlow_s = sat_inc(hlow_r);
    end else begin
      hlow_s = hlow_r;
    end
  end

  // The first hsync fall after reset has no previous line to measure.
  assign hper_ev_s = hfall_s & h_seen_r & (hcount_r != H_LAST);
  assign vper_ev_s = vfall_s & (state_r != ST_IDLE) & (vcount_r != V_LAST);
  assign hwid_ev_s = hrise_s & (hlow_r != H_SYNC_W);
  assign err_ev_s  = hper_ev_s | vper_ev_s | hwid_ev_s;

  assign vis_s = (hcount_s >= H_ACT_LO) && (hcount_s < H_ACT_HI) &&
                 (vcount_s >= V_ACT_LO) && (vcount_s < V_ACT_HI);

  // Running frame sum; restarted at every frame boundary and on any error.
  always_comb begin
    sum_s = sum_r;
    cnt_s = cnt_r;
    if (vfall_s || err_ev_s) begin
      sum_s = 32'd0;
      cnt_s = 19'd0;
    end else if (vis_s) begin
      sum_s = sum_r + {20'd0, pix_r};
      cnt_s = cnt_r + 19'd1;
    end else begin
      sum_s = sum_r;
      cnt_s = cnt_r;
    end
  end

  // Lock state machine: next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    state_s = vfall_s ? ST_MEASURE : ST_IDLE;
      ST_MEASURE: state_s = (vfall_s && !err_ev_s) ? ST_LOCKED : ST_MEASURE;
      ST_LOCKED:  state_s = err_ev_s ? ST_MEASURE : ST_LOCKED;
      default:    state_s = ST_IDLE;
    endcase
  end

  assign latch_s = (state_r == ST_LOCKED) & vfall_s & ~err_ev_s;

  // Measurement counters, running sum and lock state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
      hlow_r   <= 10'd0;
      h_seen_r <= 1'b0;
      sum_r    <= 32'd0;
      cnt_r    <= 19'd0;
      state_r  <= ST_IDLE;
    end else begin
      hcount_r <= hcount_s;
      vcount_r <= vcount_s;
      hlow_r   <= hlow_s;
      h_seen_r <= h_seen_r | hfall_s;
      sum_r    <= sum_s;
      cnt_r    <= cnt_s;
      state_r  <= state_s;
    end
  end

  // Registered outputs; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      checksum    <= 32'd0;
      pix_count   <= 19'd0;
      err_hperiod <= 1'b0;
      err_vperiod <= 1'b0;
      err_hwidth  <= 1'b0;
    end else begin
      locked     <= (state_s == ST_LOCKED);
      frame_done <= latch_s;
      if (latch_s) begin
        checksum    <= sum_r;
        pix_count   <= cnt_r;
        frame_count <= frame_count + 16'd1;
      end
      err_hperiod <= hper_ev_s | (err_hperiod & ~clr_err);
      err_vperiod <= vper_ev_s | (err_vperiod & ~clr_err);
      err_hwidth  <= hwid_ev_s | (err_hwidth & ~clr_err);
    end
  end

endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor using a scaled-down timing (17 clocks x 11
// lines, 8x6 visible) so whole frames stay short; expectations are hand-computed.
module tb_vga_monitor;

  localparam int HV = 8, HF = 2, HS = 4, HB = 3, HT = 17;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, clr_err = 1'b0;
  logic [3:0]  r = 4'd0, g = 4'd0, b = 4'd0;
  logic        locked, frame_done, err_hperiod, err_vperiod, err_hwidth;
  logic [15:0] frame_count;
  logic [31:0] checksum;
  logic [18:0] pix_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic       mid_lk_v;
  logic [2:0] mid_err_v;

  typedef struct {
    logic [11:0] pix;
    logic        short_line;
    int          hsw;
    int          nlines;
    logic        clr;
    logic        mid_lk;
    logic [2:0]  mid_err;
    logic        lk;
    int          done;
    logic [15:0] fc;
    logic [31:0] cs;
    logic [18:0] pc;
    logic [2:0]  err;
  } row_t;

  row_t rows [11];

  vga_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .clr_err(clr_err),
    .locked(locked), .frame_done(frame_done), .frame_count(frame_count),
    .checksum(checksum), .pix_count(pix_count),
    .err_hperiod(err_hperiod), .err_vperiod(err_vperiod), .err_hwidth(err_hwidth)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start of line 0 of a new frame: both syncs low for the hsync width.
  task automatic frame_close();
    for (int h = 0; h < HS; h++) begin
      hsync = 1'b0; vsync = 1'b0; {r, g, b} = 12'd0; clr_err = 1'b0;
      step();
    end
  endtask

  // Rest of a frame; line 5 may be short or carry a bad hsync width.
  task automatic run_frame(input logic [11:0] pix, input logic short_line,
                           input int hsw, input int nlines, input logic clr);
    for (int v = 0; v < nlines; v++) begin
      int len;
      int hw;
      len = (short_line && v == 5) ? HT - 1 : HT;
      hw  = (v == 5) ? hsw : HS;
      for (int h = (v == 0) ? HS : 0; h < len; h++) begin
        if (v == 8 && h == 0) begin
          mid_lk_v  = locked;
          mid_err_v = {err_hperiod, err_vperiod, err_hwidth};
        end
        hsync = (h < hw) ? 1'b0 : 1'b1;
        vsync = (v < VS) ? 1'b0 : 1'b1;
        if (h >= HS + HB && h < HS + HB + HV && v >= VS + VB && v < VS + VB + VV)
          {r, g, b} = pix;
        else
          {r, g, b} = 12'd0;
        clr_err = (clr && v == 0 && h == HS) ? 1'b1 : 1'b0;
        step();
      end
    end
  endtask

  task automatic chk_outputs(input string tag, input logic lk, input int done,
                             input logic [15:0] fc, input logic [31:0] cs,
                             input logic [18:0] pc, input logic [2:0] err);
    chk({tag, " locked"}, {31'd0, locked}, {31'd0, lk});
    chk({tag, " frame_done_count"}, done_cnt, done);
    chk({tag, " frame_count"}, {16'd0, frame_count}, {16'd0, fc});
    chk({tag, " checksum"}, checksum, cs);
    chk({tag, " pix_count"}, {13'd0, pix_count}, {13'd0, pc});
    chk({tag, " err_flags"}, {29'd0, err_hperiod, err_vperiod, err_hwidth}, {29'd0, err});
  endtask

  initial begin
    //           pix      short  hsw nl  clr   midlk midErr  lk  done fc      cs            pc      err
    rows[0]  = '{12'hFFF, 1'b0, 4, 11, 1'b0, 1'b0, 3'b000, 1'b1, 0, 16'd0, 32'h0,       19'd0,  3'b000};
    rows[1]  = '{12'hFFF, 1'b0, 4, 11, 1'b0, 1'b1, 3'b000, 1'b1, 1, 16'd1, 32'h0002FFD0, 19'd48, 3'b000};
    rows[2]  = '{12'h000, 1'b0, 4, 11, 1'b0, 1'b1, 3'b000, 1'b1, 2, 16'd2, 32'h0,       19'd48, 3'b000};
    rows[3]  = '{12'h123, 1'b0, 4, 11, 1'b0, 1'b1, 3'b000, 1'b1, 3, 16'd3, 32'h00003690, 19'd48, 3'b000};
    rows[4]  = '{12'hABC, 1'b1, 4, 11, 1'b0, 1'b0, 3'b100, 1'b1, 3, 16'd3, 32'h00003690, 19'd48, 3'b100};
    rows[5]  = '{12'hFFF, 1'b0, 4, 11, 1'b0, 1'b1, 3'b100, 1'b1, 4, 16'd4, 32'h0002FFD0, 19'd48, 3'b100};
    rows[6]  = '{12'h000, 1'b0, 3, 11, 1'b1, 1'b0, 3'b001, 1'b1, 4, 16'd4, 32'h0002FFD0, 19'd48, 3'b001};
    rows[7]  = '{12'hFFF, 1'b0, 4, 11, 1'b1, 1'b1, 3'b000, 1'b1, 5, 16'd5, 32'h0002FFD0, 19'd48, 3'b000};
    rows[8]  = '{12'hFFF, 1'b0, 4, 10, 1'b0, 1'b1, 3'b000, 1'b0, 5, 16'd5, 32'h0002FFD0, 19'd48, 3'b010};
    rows[9]  = '{12'h001, 1'b0, 4, 11, 1'b0, 1'b0, 3'b010, 1'b1, 5, 16'd5, 32'h0002FFD0, 19'd48, 3'b010};
    rows[10] = '{12'h001, 1'b0, 4, 11, 1'b0, 1'b1, 3'b010, 1'b1, 6, 16'd6, 32'h00000030, 19'd48, 3'b010};

    #1 rst = 1'b0;
    #1 chk_outputs("reset", 1'b0, 0, 16'd0, 32'd0, 19'd0, 3'b000);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();

    frame_close();
    chk("first_vfall locked", {31'd0, locked}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_frame(rows[i].pix, rows[i].short_line, rows[i].hsw, rows[i].nlines, rows[i].clr);
      frame_close();
      chk($sformatf("row%0d mid_locked", i), {31'd0, mid_lk_v}, {31'd0, rows[i].mid_lk});
      chk($sformatf("row%0d mid_err", i), {29'd0, mid_err_v}, {29'd0, rows[i].mid_err});
      chk_outputs($sformatf("row%0d", i), rows[i].lk, rows[i].done, rows[i].fc,
                  rows[i].cs, rows[i].pc, rows[i].err);
    end

    // Reset in the middle of a frame, then relock after two vsync falls.
    for (int v = 0; v < 5; v++) begin
      for (int h = (v == 0) ? HS : 0; h < HT; h++) begin
        hsync = (h < HS) ? 1'b0 : 1'b1;
        vsync = (v < VS) ? 1'b0 : 1'b1;
        {r, g, b} = 12'hFFF;
        step();
      end
    end
    hsync = 1'b1; vsync = 1'b1;
    rst = 1'b0;
    #1 chk_outputs("midrst", 1'b0, 6, 16'd0, 32'd0, 19'd0, 3'b000);
    chk("midrst frame_done", {31'd0, frame_done}, 32'd0);
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();
    frame_close();
    chk("midrst vfall1 locked", {31'd0, locked}, 32'd0);
    run_frame(12'hFFF, 1'b0, HS, 11, 1'b0);
    frame_close();
    chk_outputs("midrst vfall2", 1'b1, 6, 16'd0, 32'd0, 19'd0, 3'b000);
    run_frame(12'hFFF, 1'b0, HS, 11, 1'b0);
    frame_close();
    chk_outputs("midrst vfall3", 1'b1, 7, 16'd1, 32'h0002FFD0, 19'd48, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
